seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised successor to the single-digit seven-segment decoder. It drives an N-digit common-enable multiplexed display from a binary value, in hex or decimal mode. Decimal mode uses a sequential double-dabble converter. Features: leading-zero blanking, per-digit dots, overflow indication and a programmable refresh rate. Sits between CALCUL-style counters and the DIG_x/SEG_x pins of the Omdazz top.

Parameters:
N_DIG, 4, number of digits scanned (1..8)
DATA_W, 16, width of binary input (1..32; hex mode requires DATA_W <= 4*N_DIG)
REFRESH_DIV, 50000, FPGA_CLK cycles per digit slot (>= 2); 50000 gives 1 kHz slot rate at 50 MHz
SEG_ACTIVE_LOW, 1, 1: segment/dot outputs low = lit
DIG_ACTIVE_LOW, 1, 1: dig_en low = digit selected

Ports:
FPGA_CLK  input  1  system clock, 50 MHz
RESET_BUT  input  1  asynchronous active-high reset; the top inverts the physical button
data  input  DATA_W  binary value, sampled on load
load  input  1  one-cycle strobe requesting a display update
dec_mode  input  1  1: decimal display, 0: hex; sampled on load
blank_lz  input  1  1: blank leading zeros; sampled live
dots  input  N_DIG  per-digit decimal point request, bit i = digit i; sampled live
busy  output  1  decimal conversion in progress
segment  output  7  segments {a,b,c,d,e,f,g}, g = LSB, registered
dot  output  1  decimal point of the currently selected digit, registered
dig_en  output  N_DIG  one-hot digit select, bit 0 = rightmost/least significant, registered

Behaviour:
- Reset (async, while RESET_BUT=1):
  - busy=0; segment all off; dot off; dig_en all inactive.
  - Refresh counter=0, digit index=0, display digit registers=0, overflow flag=0.
- Display registers: N_DIG 4-bit digit codes plus an overflow flag, updated atomically only. Scanning continues on the old contents during a conversion.
- Load accepted only when busy=0; load while busy=1 is ignored entirely (no queueing).
- Hex load (dec_mode=0): digit i <= data[4i+3:4i] (zero-extended), overflow=0. Registers update on the clock edge after the load cycle. busy stays 0.
- Decimal load (dec_mode=1):
  - If data > 10^N_DIG-1 (localparam compare in the load cycle): overflow<=1 next cycle, busy stays 0.
  - Otherwise busy rises the cycle after load and stays high for exactly DATA_W cycles, one shift/add-3 iteration per cycle over a 4*N_DIG-bit BCD register.
  - On the last iteration edge, the display registers take the BCD result, overflow<=0 and busy<=0.
- FSM states: IDLE -> CONV (on accepted decimal non-overflow load) -> IDLE after DATA_W iterations. The iteration counter is cleared on entry.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps. On wrap, the digit index advances; it wraps from N_DIG-1 to 0.
  - Outputs are registered from the current index: the first cycle after reset release already selects digit 0.
  - Each digit is shown for exactly REFRESH_DIV cycles.
- Segment code (active-low form, {a..g}):
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F, 8:00, 9:04, A:08, b:60, C:31, d:42, E:30, F:38.
  - "-" = 7E. Blank = 7F.
  - SEG_ACTIVE_LOW=0 inverts segment and dot.
- Overflow: every digit shows "-"; dots still honoured.
- Leading-zero blanking: digit i (i>0) is blank when blank_lz=1 and digits i..N_DIG-1 are all zero. Digit 0 is never blanked. Blanking does not apply during overflow.
- dot = dots[index] (lit when 1), independent of blanking.
- Reset mid-conversion aborts: busy=0, display registers=0.

Test Plan:
- Bench params: REFRESH_DIV=4, N_DIG=4, DATA_W=16.
- Scan timing: after reset, dig_en = 1110 for 4 cycles, then 1101, 1011, 0111, 1110, ...; segment=01 (digit "0") on every slot.
- Hex: load data=16'hA5C3, dec_mode=0 -> busy never rises; next frame shows digit0=06, digit1=31, digit2=24, digit3=08.
- Decimal:
  - load data=1234, dec_mode=1 -> busy high exactly 16 cycles starting the cycle after load; the old display is held until busy falls.
  - Then digit0=4C, digit1=06, digit2=12, digit3=4F.
- Overflow/blanking:
  - load 10000 decimal -> busy stays 0; all digits 7E.
  - Then load 7 with blank_lz=1 -> digits 3..1 = 7F, digit0 = 0F.
  - Then load 0 -> digit0 = 01, others 7F.
- Handshake/reset:
  - load 9999 decimal, then assert load with data=1 three cycles later -> second load ignored; result shows 9999 (04 on all digits).
  - Assert RESET_BUT mid-conversion -> busy=0 immediately; all outputs at reset values.
- Dots/polarity: dots=4'b0100 -> dot lit only while dig_en=1011.
  - Rerun the hex case with SEG_ACTIVE_LOW=0 and DIG_ACTIVE_LOW=0 -> bitwise-inverted segment, dot and dig_en values.

Source files
------------

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver: hex or decimal (sequential double-dabble)
// display registers, leading-zero blanking, per-digit dots and overflow dashes.
module seg_scan_driver #(
   parameter int N_DIG          = 4,
   parameter int DATA_W         = 16,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic              FPGA_CLK,
   input  logic              RESET_BUT,
   input  logic [DATA_W-1:0] data,
   input  logic              load,
   input  logic              dec_mode,
   input  logic              blank_lz,
   input  logic [N_DIG-1:0]  dots,
   output logic              busy,
   output logic [6:0]        segment,
   output logic              dot,
   output logic [N_DIG-1:0]  dig_en
);

   localparam int BCD_W  = 4 * N_DIG;
   localparam int EXT_W  = (DATA_W > BCD_W) ? DATA_W : BCD_W;
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0]      DEC_MAX = pow10(N_DIG) - 64'd1;
   localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic             DOT_OFF = SEG_ACTIVE_LOW;
   localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACTIVE_LOW}};

   // Active-low {a..g} patterns; polarity is applied once at the output register.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'h0: return 7'h01;
         4'h1: return 7'h4F;
         4'h2: return 7'h12;
         4'h3: return 7'h06;
         4'h4: return 7'h4C;
         4'h5: return 7'h24;
         4'h6: return 7'h20;
         4'h7: return 7'h0F;
         4'h8: return 7'h00;
         4'h9: return 7'h04;
         4'hA: return 7'h08;
         4'hB: return 7'h60;
         4'hC: return 7'h31;
         4'hD: return 7'h42;
         4'hE: return 7'h30;
         default: return 7'h38;
      endcase
   endfunction

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_hex_load;
   logic               w_ovf_load;
   logic               w_dec_start;
   logic               w_conv_done;

   logic [DATA_W-1:0]  r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [ITER_W-1:0]  r_iter;
   logic [BCD_W-1:0]   r_disp;
   logic               r_ovf;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [BCD_W-1:0]   w_bcd_next;
   logic [EXT_W-1:0]   w_data_ext;
   logic [63:0]        w_data_wide;

   logic [CNT_W-1:0]   r_refresh_cnt;
   logic [IDX_W-1:0]   r_dig_idx;
   logic [N_DIG-1:0]   w_lz;
   logic               w_zero_above;
   logic [3:0]         w_cur_code;
   logic               w_cur_dot;
   logic               w_cur_blank;
   logic [N_DIG-1:0]   w_sel;
   logic [6:0]         w_seg_raw;

   assign w_data_ext  = EXT_W'(data);
   assign w_data_wide = 64'(data);
   assign busy        = (r_state == S_CONV);

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values; combinational blocks use blocking ones.
   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_hex_load  = 1'b0;
      w_ovf_load  = 1'b0;
      w_dec_start = 1'b0;
      w_conv_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load) begin
               if (!dec_mode) begin
                  w_hex_load = 1'b1;
               end else if (w_data_wide > DEC_MAX) begin
                  w_ovf_load = 1'b1;
               end else begin
                  w_dec_start = 1'b1;
                  w_state_nxt = S_CONV;
               end
            end
         end
         S_CONV: begin
            if (r_iter == ITER_W'(DATA_W - 1)) begin
               w_conv_done = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Double-dabble step: add 3 to every BCD nibble >= 5, then shift in the next binary bit.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < N_DIG; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};

   // Display registers change only as a whole, so scanning never shows a half-converted value.
   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_iter <= '0;
         r_disp <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_hex_load) begin
            r_disp <= w_data_ext[BCD_W-1:0];
            r_ovf  <= 1'b0;
         end
         if (w_ovf_load) r_ovf <= 1'b1;
         if (w_dec_start) begin
            r_bin  <= data;
            r_bcd  <= '0;
            r_iter <= '0;
         end else if (r_state == S_CONV) begin
            r_bin  <= r_bin << 1;
            r_bcd  <= w_bcd_next;
            r_iter <= r_iter + 1'b1;
         end
         if (w_conv_done) begin
            r_disp <= w_bcd_next;
            r_ovf  <= 1'b0;
         end
      end
   end

   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         r_refresh_cnt <= '0;
         r_dig_idx     <= '0;
      end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         r_refresh_cnt <= '0;
         r_dig_idx     <= (r_dig_idx == IDX_W'(N_DIG - 1)) ? '0 : r_dig_idx + 1'b1;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
   end

   // A digit is a leading zero when it and every more significant digit are zero.
   always_comb begin
      w_lz         = '0;
      w_zero_above = 1'b1;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         w_zero_above = w_zero_above & (r_disp[4*i +: 4] == 4'd0);
         w_lz[i]      = blank_lz & w_zero_above & (i != 0);
      end
   end

   always_comb begin
      w_cur_code  = 4'd0;
      w_cur_dot   = 1'b0;
      w_cur_blank = 1'b0;
      w_sel       = '0;
      for (int i = 0; i < N_DIG; i++) begin
         if (r_dig_idx == IDX_W'(i)) begin
            w_cur_code  = r_disp[4*i +: 4];
            w_cur_dot   = dots[i];
            w_cur_blank = w_lz[i];
            w_sel[i]    = 1'b1;
         end
      end
   end

   assign w_seg_raw = r_ovf       ? 7'h7E :
                      w_cur_blank ? 7'h7F : seg_decode(w_cur_code);

   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         segment <= SEG_OFF;
         dot     <= DOT_OFF;
         dig_en  <= DIG_OFF;
      end else begin
         segment <= SEG_ACTIVE_LOW ? w_seg_raw : ~w_seg_raw;
         dot     <= SEG_ACTIVE_LOW ? ~w_cur_dot : w_cur_dot;
         dig_en  <= DIG_ACTIVE_LOW ? ~w_sel : w_sel;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected digit slots are queued with each
// stimulus and compared against both an active-low and an active-high instance.
module tb_seg_scan_driver;

   localparam int N_DIG       = 4;
   localparam int DATA_W      = 16;
   localparam int REFRESH_DIV = 4;

   localparam logic [6:0] SEG_TAB [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
   localparam logic [6:0] SEG_DASH  = 7'h7E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic              clk = 1'b0;
   logic              RESET_BUT;
   logic [DATA_W-1:0] data;
   logic              load;
   logic              dec_mode;
   logic              blank_lz;
   logic [N_DIG-1:0]  dots;
   logic              busy,      busy_i;
   logic [6:0]        segment,   segment_i;
   logic              dot,       dot_i;
   logic [N_DIG-1:0]  dig_en,    dig_en_i;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [N_DIG-1:0] dig_en;
      logic [6:0]       seg;
      logic             dot;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   seg_scan_driver #(
      .N_DIG(N_DIG), .DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV),
      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .FPGA_CLK(clk), .RESET_BUT(RESET_BUT), .data(data), .load(load),
      .dec_mode(dec_mode), .blank_lz(blank_lz), .dots(dots),
      .busy(busy), .segment(segment), .dot(dot), .dig_en(dig_en)
   );

   seg_scan_driver #(
      .N_DIG(N_DIG), .DATA_W(DATA_W), .REFRESH_DIV(REFRESH_DIV),
      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
   ) dut_inv (
      .FPGA_CLK(clk), .RESET_BUT(RESET_BUT), .data(data), .load(load),
      .dec_mode(dec_mode), .blank_lz(blank_lz), .dots(dots),
      .busy(busy_i), .segment(segment_i), .dot(dot_i), .dig_en(dig_en_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_slot(input int idx, input logic [6:0] seg_al, input logic lit);
      exp_t e;
      e.dig_en      = '1;
      e.dig_en[idx] = 1'b0;
      e.seg         = seg_al;
      e.dot         = ~lit;
      sb_q.push_back(e);
   endtask

   task automatic expect_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                               input logic [6:0] s0, input logic [N_DIG-1:0] lit);
      expect_slot(0, s0, lit[0]);
      expect_slot(1, s1, lit[1]);
      expect_slot(2, s2, lit[2]);
      expect_slot(3, s3, lit[3]);
   endtask

   task automatic compare_now();
      exp_t             e;
      logic [N_DIG-1:0] inv_den;
      logic [6:0]       inv_seg;
      logic             inv_dot;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 1, 0);
         return;
      end
      e       = sb_q.pop_front();
      inv_den = ~e.dig_en;
      inv_seg = ~e.seg;
      inv_dot = ~e.dot;
      check("dig_en",      dig_en,    e.dig_en);
      check("segment",     segment,   e.seg);
      check("dot",         dot,       e.dot);
      check("dig_en_inv",  dig_en_i,  inv_den);
      check("segment_inv", segment_i, inv_seg);
      check("dot_inv",     dot_i,     inv_dot);
   endtask

   // Align to the first cycle of a digit-0 slot, then compare one sample per slot.
   task automatic check_frame();
      int n;
      n = 0;
      while (dig_en == 4'b1110 && n < 64) begin
         tick();
         n++;
      end
      while (dig_en != 4'b1110 && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) begin
         check("frame_align_timeout", n, 0);
         sb_q.delete();
         return;
      end
      for (int s = 0; s < N_DIG; s++) begin
         compare_now();
         if (s < N_DIG - 1) repeat (REFRESH_DIV) tick();
      end
   endtask

   task automatic do_load(input logic [DATA_W-1:0] d, input logic dm);
      data     = d;
      dec_mode = dm;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int               n;
      int               bad;
      int               idx;
      logic             seen;
      logic [6:0]       old_seg [N_DIG];

      RESET_BUT = 1'b1;
      load      = 1'b0;
      data      = '0;
      dec_mode  = 1'b0;
      blank_lz  = 1'b0;
      dots      = '0;
      repeat (3) tick();

      check("rst_busy",    busy,      0);
      check("rst_seg",     segment,   7'h7F);
      check("rst_dot",     dot,       1);
      check("rst_dig",     dig_en,    4'hF);
      check("rst_seg_inv", segment_i, 0);
      check("rst_dot_inv", dot_i,     0);
      check("rst_dig_inv", dig_en_i,  0);

      // Scan timing: four cycles per digit, starting on digit 0 right after release.
      RESET_BUT = 1'b0;
      for (int c = 0; c < 4 * N_DIG; c++) expect_slot(c / REFRESH_DIV, SEG_TAB[0], 1'b0);
      for (int c = 0; c < 4 * N_DIG; c++) begin
         tick();
         compare_now();
      end
      expect_slot(0, SEG_TAB[0], 1'b0);
      tick();
      compare_now();

      // Hex load: no conversion, display follows immediately.
      do_load(16'hA5C3, 1'b0);
      check("hex_busy", busy, 0);
      expect_frame(SEG_TAB[10], SEG_TAB[5], SEG_TAB[12], SEG_TAB[3], 4'b0000);
      check_frame();
      check("hex_busy_after", busy, 0);

      // Decimal load: busy for DATA_W cycles while the old hex value stays on screen.
      old_seg = '{SEG_TAB[3], SEG_TAB[12], SEG_TAB[5], SEG_TAB[10]};
      do_load(16'd1234, 1'b1);
      n   = 0;
      bad = 0;
      while (busy && n < 100) begin
         idx = 0;
         for (int i = 0; i < N_DIG; i++) if (!dig_en[i]) idx = i;
         if (segment != old_seg[idx]) bad++;
         n++;
         tick();
      end
      check("dec_busy_len", n, 16);
      check("dec_hold_old", bad, 0);
      expect_frame(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 4'b0000);
      check_frame();

      // Overflow: no conversion, dashes everywhere.
      do_load(16'd10000, 1'b1);
      seen = busy;
      repeat (3) begin
         tick();
         seen = seen | busy;
      end
      check("ovf_busy", seen, 0);
      expect_frame(SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, 4'b0000);
      check_frame();

      // Leading-zero blanking.
      blank_lz = 1'b1;
      do_load(16'd7, 1'b1);
      count_busy(n);
      check("lz7_busy_len", n, 16);
      expect_frame(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_TAB[7], 4'b0000);
      check_frame();

      do_load(16'd0, 1'b1);
      count_busy(n);
      check("lz0_busy_len", n, 16);
      expect_frame(SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_TAB[0], 4'b0000);
      check_frame();
      blank_lz = 1'b0;

      // A load during conversion is dropped, not queued.
      do_load(16'd9999, 1'b1);
      tick();
      tick();
      do_load(16'd1, 1'b1);
      check("ign_busy_still", busy, 1);
      count_busy(n);
      check("ign_busy_len", n + 3, 16);
      tick();
      check("ign_no_restart", busy, 0);
      expect_frame(SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], 4'b0000);
      check_frame();

      // Dots are live and independent of the digit value.
      dots = 4'b0100;
      expect_frame(SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], SEG_TAB[9], 4'b0100);
      check_frame();
      dots = 4'b0000;

      // Reset mid-conversion aborts and clears the display.
      do_load(16'd1234, 1'b1);
      repeat (5) tick();
      check("mid_busy_pre", busy, 1);
      RESET_BUT = 1'b1;
      #1;
      check("mid_rst_busy", busy,     0);
      check("mid_rst_seg",  segment,  7'h7F);
      check("mid_rst_dot",  dot,      1);
      check("mid_rst_dig",  dig_en,   4'hF);
      check("mid_rst_busy_inv", busy_i, 0);
      tick();
      RESET_BUT = 1'b0;
      expect_frame(SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], SEG_TAB[0], 4'b0000);
      check_frame();
      check("mid_rst_idle", busy, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
